console_bus_arbiter: RTL and testbench
======================================

// Module: console_bus_arbiter
// PURPOSE
//  Parametrised N-master front end for the console memory bus: CPU, DMA, blitter etc. share one downstream port into memory_system.
//  Round-robin arbitration, one outstanding transaction, per-master grant/response handshake.
//  Sits between the bus masters and the MEMORY_SYSTEM side of mem_bus; memory_system still decodes RAM / frame buffer / sys_io.
// PARAMETERS
//  NUM_MASTERS     3    requesters, 1..8
//  ADDR_WIDTH      16   bus address width
//  DATA_WIDTH      8    bus data width
//  TIMEOUT_CYCLES  255  BUSY cycles before abort; only with ARB_TIMEOUT_EN
// PORTS
//  clk_in          in   1        system clock
//  rst_in          in   1        reset, synchronous, active-low
//  m_req_in        in   N        per-master request, held until grant
//  m_we_in         in   N        per-master write enable
//  m_addr_in       in   N*AW     per-master address, packed [N-1:0][AW-1:0]
//  m_wdata_in      in   N*DW     per-master write data, packed
//  m_gnt_out       out  N        one-hot, 1-cycle pulse: request accepted
//  m_rvalid_out    out  N        one-hot, 1-cycle pulse: transaction complete
//  m_rdata_out     out  DW       read data, valid with m_rvalid_out (shared)
//  m_err_out       out  1        transaction aborted, valid with m_rvalid_out
//  s_req_out       out  1        downstream request, held until s_ack_in
//  s_we_out        out  1        downstream write enable
//  s_addr_out      out  AW       downstream address
//  s_wdata_out     out  DW       downstream write data
//  s_ack_in        in   1        downstream done; s_rdata_in valid this cycle
//  s_rdata_in      in   DW       downstream read data
//  owner_out       out  clog2N   id of current/last granted master
//  stray_ack_out   out  1        sticky: s_ack_in seen while not BUSY
// BEHAVIOUR
//  Reset (rst_in==0 at posedge):
//   - All outputs 0; state IDLE; last-grant pointer = N-1, so master 0 wins first.
//   - Any in-flight transaction is dropped silently, with no rvalid.
//  All outputs are registered.
//  FSM IDLE -> BUSY -> RESP -> IDLE:
//   - IDLE: if any m_req_in, pick the first set bit scanning from pointer+1 (mod N). Next cycle:
//     - m_gnt_out[w] = 1 for one cycle;
//     - s_req_out = 1, with we/addr/wdata latched from master w;
//     - owner_out = w; go BUSY.
//   - BUSY: s_* held stable. On s_ack_in (may arrive in the first BUSY cycle):
//     - latch s_rdata_in; go RESP.
//     - s_req_out deasserts the cycle after ack.
//   - RESP: m_rvalid_out[owner] = 1 for one cycle, plus m_rdata_out. Writes also get rvalid (data don't-care).
//     Pointer = owner; go IDLE.
//  Latency: req sampled at t -> gnt at t+1 -> ack earliest t+1 -> rvalid t+2. Maximum rate 1 transaction / 3 cycles.
//  Boundary cases:
//   - Master drops req before being sampled: not granted; legal.
//   - Single active master: granted every slot.
//   - All masters requesting: strict rotation 0,1,2,0...
//   - m_req_in ignored outside IDLE.
//   - s_ack_in outside BUSY: ignored; sets stray_ack_out until reset.
//   - Address/data are passed through unmodified; no width conversion.
// CONFIGURATION
//  Macro ARB_TIMEOUT_EN.
//   Defined:
//    - BUSY counter saturates at TIMEOUT_CYCLES; on reaching it, s_req_out drops, go RESP.
//    - RESP then gives m_err_out = 1 with m_rdata_out = all-ones.
//    - Counter clears on entering BUSY.
//    - An ack arriving in the same cycle as expiry wins: normal completion, no error.
//   Undefined: no counter; BUSY waits indefinitely; m_err_out tied 0.
// STRUCTURE
//  Package console_bus_pkg:
//   - arb_state_t enum {IDLE, BUSY, RESP};
//   - ARB_ERR_DATA constant;
//   - master_id_t sized from MAX_MASTERS = 8.
//  Sub-module rr_pick: combinational rotate-priority one-hot select from request vector and pointer. Instanced once.
// TESTING
//  1. Reset, then idle 10 cycles -> all outputs 0, stray_ack_out 0.
//  2. m0 read 0x1234, ack after 3 cycles, s_rdata_in = 0xA5 -> gnt[0] at t+1, rvalid[0] at t+5, m_rdata_out 0xA5.
//  3. m0, m1, m2 requesting continuously, ack immediately -> grants 0,1,2,0,1,2 every 3 cycles.
//  4. rst_in low during BUSY -> next cycle s_req_out 0, no rvalid; next grant goes to master 0.
//  5. Ack pulse while IDLE -> stray_ack_out 1, no state change, no rvalid.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, never ack -> s_req_out drops after 4 BUSY cycles; rvalid with m_err_out 1, data 0xFF.

Source files
------------

// File: rtl/console_bus_pkg.sv
// Shared types and constants for the console memory bus arbiter.
package console_bus_pkg;

   localparam int unsigned MAX_MASTERS    = 8;
   localparam int unsigned MAX_DATA_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef logic [$clog2(MAX_MASTERS)-1:0] master_id_t;

   // Read data returned on an aborted transaction, truncated to the bus width at use.
   localparam logic [MAX_DATA_WIDTH-1:0] ARB_ERR_DATA = '1;

endpackage

// File: rtl/console_bus_arbiter_rr_pick.sv
// Rotating-priority one-hot select: first request strictly after ptr_i, wrapping to bit 0.
module rr_pick #(
   parameter int unsigned N    = 3,
   parameter int unsigned ID_W = 2
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [N-1:0]    gnt_oh_c,
   output logic [ID_W-1:0] gnt_id_c
);

   logic [N-1:0] hi_c;
   logic [N-1:0] sel_c;

   // Requests above the pointer take priority; otherwise wrap around to the full vector.
   always_comb begin
      hi_c     = '0;
      gnt_oh_c = '0;
      gnt_id_c = '0;
      for (int i = 0; i < int'(N); i++) begin
         hi_c[i] = req_i[i] && (i > int'(ptr_i));
      end
      sel_c = (|hi_c) ? hi_c : req_i;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (sel_c[i]) begin
            gnt_oh_c    = '0;
            gnt_oh_c[i] = 1'b1;
            gnt_id_c    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/console_bus_arbiter.sv
// N-master round-robin front end for the console memory bus, one transaction in flight.
// Optional BUSY timeout with error response when ARB_TIMEOUT_EN is defined.
module console_bus_arbiter
   import console_bus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 3,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 8,
`ifdef ARB_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
   localparam int unsigned ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                                    clk_in,
   input  logic                                    rst_in,
   input  logic [NUM_MASTERS-1:0]                  m_req_in,
   input  logic [NUM_MASTERS-1:0]                  m_we_in,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  m_addr_in,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  m_wdata_in,
   output logic [NUM_MASTERS-1:0]                  m_gnt_out,
   output logic [NUM_MASTERS-1:0]                  m_rvalid_out,
   output logic [DATA_WIDTH-1:0]                   m_rdata_out,
   output logic                                    m_err_out,
   output logic                                    s_req_out,
   output logic                                    s_we_out,
   output logic [ADDR_WIDTH-1:0]                   s_addr_out,
   output logic [DATA_WIDTH-1:0]                   s_wdata_out,
   input  logic                                    s_ack_in,
   input  logic [DATA_WIDTH-1:0]                   s_rdata_in,
   output logic [ID_W-1:0]                         owner_out,
   output logic                                    stray_ack_out
);

   arb_state_t                 state_q, state_d;
   logic [ID_W-1:0]            ptr_q, ptr_d;
   logic [ID_W-1:0]            owner_q, owner_d;
   logic [NUM_MASTERS-1:0]     gnt_q, gnt_d;
   logic [NUM_MASTERS-1:0]     rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic                       s_req_q, s_req_d;
   logic                       s_we_q, s_we_d;
   logic [ADDR_WIDTH-1:0]      s_addr_q, s_addr_d;
   logic [DATA_WIDTH-1:0]      s_wdata_q, s_wdata_d;
   logic                       stray_q, stray_d;
   logic [NUM_MASTERS-1:0]     pick_oh;
   logic [ID_W-1:0]            pick_id;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             expire_c;

   // Expiry fires in the TIMEOUT_CYCLES-th BUSY cycle (counter starts at 0).
   assign expire_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   rr_pick #(
      .N    (NUM_MASTERS),
      .ID_W (ID_W)
   ) u_pick (
      .req_i    (m_req_in),
      .ptr_i    (ptr_q),
      .gnt_oh_c (pick_oh),
      .gnt_id_c (pick_id)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      gnt_d     = '0;
      rvalid_d  = '0;
      rdata_d   = rdata_q;
      s_req_d   = s_req_q;
      s_we_d    = s_we_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      stray_d   = stray_q | (s_ack_in && (state_q != BUSY));
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|m_req_in) begin
               gnt_d     = pick_oh;
               s_req_d   = 1'b1;
               s_we_d    = m_we_in[pick_id];
               s_addr_d  = m_addr_in[pick_id];
               s_wdata_d = m_wdata_in[pick_id];
               owner_d   = pick_id;
               state_d   = BUSY;
`ifdef ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         // Ack is checked first so it wins over a simultaneous timeout.
         BUSY: begin
            if (s_ack_in) begin
               rvalid_d[owner_q] = 1'b1;
               rdata_d           = s_rdata_in;
               s_req_d           = 1'b0;
               state_d           = RESP;
            end
`ifdef ARB_TIMEOUT_EN
            else if (expire_c) begin
               rvalid_d[owner_q] = 1'b1;
               rdata_d           = DATA_WIDTH'(ARB_ERR_DATA);
               err_d             = 1'b1;
               s_req_d           = 1'b0;
               state_d           = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         RESP: begin
            ptr_d   = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q   <= IDLE;
         ptr_q     <= ID_W'(NUM_MASTERS - 1);
         owner_q   <= '0;
         gnt_q     <= '0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
         s_req_q   <= 1'b0;
         s_we_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         stray_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         s_req_q   <= s_req_d;
         s_we_q    <= s_we_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         stray_q   <= stray_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
      end
   end

   assign m_gnt_out     = gnt_q;
   assign m_rvalid_out  = rvalid_q;
   assign m_rdata_out   = rdata_q;
   assign s_req_out     = s_req_q;
   assign s_we_out      = s_we_q;
   assign s_addr_out    = s_addr_q;
   assign s_wdata_out   = s_wdata_q;
   assign owner_out     = owner_q;
   assign stray_ack_out = stray_q;
`ifdef ARB_TIMEOUT_EN
   assign m_err_out     = err_q;
`else
   assign m_err_out     = 1'b0;
`endif

endmodule

// File: tb/tb_console_bus_arbiter.sv
// Directed bench for console_bus_arbiter: vector table plus hand sequences for reset and timeout.
module tb_console_bus_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [N-1:0]          req, we;
   logic [N-1:0][AW-1:0]  addr;
   logic [N-1:0][DW-1:0]  wdata;
   logic                  ack;
   logic [DW-1:0]         srd;
   logic [N-1:0]          gnt, rvalid;
   logic [DW-1:0]         rdata;
   logic                  err, sreq, swe, stray;
   logic [AW-1:0]         saddr;
   logic [DW-1:0]         swdata;
   logic [1:0]            owner;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] exp_addr [N] = '{16'h1234, 16'h2222, 16'h3333};
   logic [DW-1:0] exp_wd   [N] = '{8'h11, 8'h22, 8'h33};
   logic          exp_we   [N] = '{1'b0, 1'b1, 1'b0};

   always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
   console_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
      .clk_in(clk), .rst_in(rst_n), .m_req_in(req), .m_we_in(we), .m_addr_in(addr),
      .m_wdata_in(wdata), .m_gnt_out(gnt), .m_rvalid_out(rvalid), .m_rdata_out(rdata),
      .m_err_out(err), .s_req_out(sreq), .s_we_out(swe), .s_addr_out(saddr),
      .s_wdata_out(swdata), .s_ack_in(ack), .s_rdata_in(srd), .owner_out(owner),
      .stray_ack_out(stray));
`else
   console_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_in(clk), .rst_in(rst_n), .m_req_in(req), .m_we_in(we), .m_addr_in(addr),
      .m_wdata_in(wdata), .m_gnt_out(gnt), .m_rvalid_out(rvalid), .m_rdata_out(rdata),
      .m_err_out(err), .s_req_out(sreq), .s_we_out(swe), .s_addr_out(saddr),
      .s_wdata_out(swdata), .s_ack_in(ack), .s_rdata_in(srd), .owner_out(owner),
      .stray_ack_out(stray));
`endif

   typedef struct {
      logic          rst;
      logic [N-1:0]  req;
      logic          ack;
      logic [DW-1:0] srd;
      logic [N-1:0]  gnt;
      logic [N-1:0]  rv;
      logic          sreq;
      logic [1:0]    owner;
      logic          stray;
      logic [DW-1:0] rdata;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t v(input logic r, input logic [N-1:0] q, input logic a,
                              input logic [DW-1:0] d, input logic [N-1:0] g,
                              input logic [N-1:0] rv, input logic sr, input logic [1:0] o,
                              input logic st, input logic [DW-1:0] rd);
      vec_t t;
      t.rst = r; t.req = q; t.ack = a; t.srd = d; t.gnt = g; t.rv = rv;
      t.sreq = sr; t.owner = o; t.stray = st; t.rdata = rd;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; ack = 1'b0; srd = '0;
      we    = {exp_we[2], exp_we[1], exp_we[0]};
      addr  = {exp_addr[2], exp_addr[1], exp_addr[0]};
      wdata = {exp_wd[2], exp_wd[1], exp_wd[0]};
      @(negedge clk);

      // Reset and idle: everything quiet.
      cyc(); cyc();
      chk("rst gnt", 32'(gnt), 0);     chk("rst rvalid", 32'(rvalid), 0);
      chk("rst sreq", 32'(sreq), 0);   chk("rst owner", 32'(owner), 0);
      chk("rst stray", 32'(stray), 0); chk("rst err", 32'(err), 0);
      chk("rst rdata", 32'(rdata), 0); chk("rst saddr", 32'(saddr), 0);
      chk("rst swe", 32'(swe), 0);     chk("rst swdata", 32'(swdata), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk($sformatf("idle%0d gnt", i), 32'(gnt), 0);
         chk($sformatf("idle%0d rvalid", i), 32'(rvalid), 0);
         chk($sformatf("idle%0d sreq", i), 32'(sreq), 0);
         chk($sformatf("idle%0d stray", i), 32'(stray), 0);
      end

      //           rst req    ack srd    gnt    rv     sreq own stray rdata
      // m0 read, ack after three BUSY cycles
      tv.push_back(v(1, 3'b001, 0, 8'h00, 3'b001, 3'b000, 1, 0, 0, 8'h00));
      tv.push_back(v(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 1, 0, 0, 8'h00));
      tv.push_back(v(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 1, 0, 0, 8'h00));
      tv.push_back(v(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 1, 0, 0, 8'h00));
      tv.push_back(v(1, 3'b000, 1, 8'hA5, 3'b000, 3'b001, 0, 0, 0, 8'hA5));
      tv.push_back(v(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 8'h00));
      // stray ack while idle
      tv.push_back(v(1, 3'b000, 1, 8'h5A, 3'b000, 3'b000, 0, 0, 1, 8'h00));
      tv.push_back(v(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 0, 0, 1, 8'h00));
      tv.push_back(v(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 0, 0, 1, 8'h00));
      tv.push_back(v(0, 3'b000, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 8'h00));
      // all masters requesting: rotation 0,1,2,0
      tv.push_back(v(1, 3'b111, 0, 8'h00, 3'b001, 3'b000, 1, 0, 0, 8'h00));
      tv.push_back(v(1, 3'b111, 1, 8'h10, 3'b000, 3'b001, 0, 0, 0, 8'h10));
      tv.push_back(v(1, 3'b111, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 8'h00));
      tv.push_back(v(1, 3'b111, 0, 8'h00, 3'b010, 3'b000, 1, 1, 0, 8'h00));
      tv.push_back(v(1, 3'b111, 1, 8'h20, 3'b000, 3'b010, 0, 1, 0, 8'h20));
      tv.push_back(v(1, 3'b111, 0, 8'h00, 3'b000, 3'b000, 0, 1, 0, 8'h00));
      tv.push_back(v(1, 3'b111, 0, 8'h00, 3'b100, 3'b000, 1, 2, 0, 8'h00));
      tv.push_back(v(1, 3'b111, 1, 8'h30, 3'b000, 3'b100, 0, 2, 0, 8'h30));
      tv.push_back(v(1, 3'b111, 0, 8'h00, 3'b000, 3'b000, 0, 2, 0, 8'h00));
      tv.push_back(v(1, 3'b111, 0, 8'h00, 3'b001, 3'b000, 1, 0, 0, 8'h00));
      tv.push_back(v(1, 3'b111, 1, 8'h40, 3'b000, 3'b001, 0, 0, 0, 8'h40));
      tv.push_back(v(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 0, 0, 0, 8'h00));
      // single active master granted every slot; a request only during RESP is not taken
      tv.push_back(v(1, 3'b100, 0, 8'h00, 3'b100, 3'b000, 1, 2, 0, 8'h00));
      tv.push_back(v(1, 3'b100, 1, 8'h77, 3'b000, 3'b100, 0, 2, 0, 8'h77));
      tv.push_back(v(1, 3'b100, 0, 8'h00, 3'b000, 3'b000, 0, 2, 0, 8'h00));
      tv.push_back(v(1, 3'b100, 0, 8'h00, 3'b100, 3'b000, 1, 2, 0, 8'h00));
      tv.push_back(v(1, 3'b000, 1, 8'h01, 3'b000, 3'b100, 0, 2, 0, 8'h01));
      tv.push_back(v(1, 3'b001, 0, 8'h00, 3'b000, 3'b000, 0, 2, 0, 8'h00));
      tv.push_back(v(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 0, 2, 0, 8'h00));

      foreach (tv[i]) begin
         rst_n = tv[i].rst; req = tv[i].req; ack = tv[i].ack; srd = tv[i].srd;
         cyc();
         chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(tv[i].gnt));
         chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(tv[i].rv));
         chk($sformatf("v%0d sreq", i), 32'(sreq), 32'(tv[i].sreq));
         chk($sformatf("v%0d owner", i), 32'(owner), 32'(tv[i].owner));
         chk($sformatf("v%0d stray", i), 32'(stray), 32'(tv[i].stray));
         chk($sformatf("v%0d err", i), 32'(err), 0);
         if (tv[i].rv != '0) chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(tv[i].rdata));
         if (tv[i].sreq) begin
            chk($sformatf("v%0d saddr", i), 32'(saddr), 32'(exp_addr[tv[i].owner]));
            chk($sformatf("v%0d swe", i), 32'(swe), 32'(exp_we[tv[i].owner]));
            chk($sformatf("v%0d swdata", i), 32'(swdata), 32'(exp_wd[tv[i].owner]));
         end
      end
      rst_n = 1'b1; req = '0; ack = 1'b0;

      // Reset during BUSY drops the transaction; pointer returns to master 0 first.
      req = 3'b010; cyc();
      chk("r4 gnt", 32'(gnt), 32'h2); chk("r4 owner", 32'(owner), 1);
      req = '0; cyc();
      chk("r4 busy sreq", 32'(sreq), 1);
      rst_n = 1'b0; cyc();
      chk("r4 rst sreq", 32'(sreq), 0); chk("r4 rst rvalid", 32'(rvalid), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("r4 post%0d rvalid", i), 32'(rvalid), 0);
         chk($sformatf("r4 post%0d sreq", i), 32'(sreq), 0);
      end
      req = 3'b111; cyc();
      chk("r4 regrant gnt", 32'(gnt), 32'h1);
      req = '0; ack = 1'b1; srd = 8'hC3; cyc();
      chk("r4 rvalid", 32'(rvalid), 32'h1); chk("r4 rdata", 32'(rdata), 32'hC3);
      ack = 1'b0; cyc();

      // Slave that never acks.
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      req = 3'b001; cyc();
      chk("to gnt", 32'(gnt), 32'h1); chk("to sreq0", 32'(sreq), 1);
      req = '0;
`ifdef ARB_TIMEOUT_EN
      for (int i = 1; i < 4; i++) begin
         cyc();
         chk($sformatf("to sreq%0d", i), 32'(sreq), 1);
         chk($sformatf("to rvalid%0d", i), 32'(rvalid), 0);
      end
      cyc();
      chk("to exp sreq", 32'(sreq), 0);   chk("to exp rvalid", 32'(rvalid), 32'h1);
      chk("to exp err", 32'(err), 1);     chk("to exp rdata", 32'(rdata), 32'hFF);
      cyc();
      chk("to resp rvalid", 32'(rvalid), 0); chk("to resp err", 32'(err), 0);
      // Ack in the expiry cycle completes normally.
      req = 3'b010; cyc();
      chk("to2 gnt", 32'(gnt), 32'h2);
      req = '0; cyc(); cyc(); cyc();
      chk("to2 sreq", 32'(sreq), 1);
      ack = 1'b1; srd = 8'h66; cyc();
      chk("to2 rvalid", 32'(rvalid), 32'h2); chk("to2 err", 32'(err), 0);
      chk("to2 rdata", 32'(rdata), 32'h66);
      ack = 1'b0; cyc();
`else
      for (int i = 1; i <= 10; i++) begin
         cyc();
         chk($sformatf("wait sreq%0d", i), 32'(sreq), 1);
         chk($sformatf("wait rvalid%0d", i), 32'(rvalid), 0);
      end
      ack = 1'b1; srd = 8'h66; cyc();
      chk("wait rvalid", 32'(rvalid), 32'h1); chk("wait err", 32'(err), 0);
      chk("wait rdata", 32'(rdata), 32'h66);
      ack = 1'b0; cyc();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
